// File: rtl/ddr_cmd_queue_pkg.sv
// Shared types for the DDR3 host command queue: FSM states, request entry layout, command codes.
package DDR3mempkg;

  localparam int unsigned CMDQ_ADDR_W = 27;
  localparam int unsigned CMDQ_DATA_W = 64;
  localparam int unsigned CMDQ_TAG_W  = 4;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  typedef enum logic [2:0] {
    Q_IDLE,
    Q_ISSUE,
    Q_WAIT_BUSY,
    Q_WAIT_DONE,
    Q_RSP
  } cmdq_state_t;

  // Request layout at the default widths.
  typedef struct packed {
    logic                   cmd;
    logic [CMDQ_ADDR_W-1:0] addr;
    logic [CMDQ_DATA_W-1:0] wdata;
    logic [CMDQ_TAG_W-1:0]  tag;
  } req_entry_t;

endpackage

// File: rtl/ddr_cmd_queue_sync_fifo.sv
// Synchronous FIFO with extra-MSB wrap pointers; head entry is presented combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ddr_cmd_queue.sv
// Host request queue in front of the DDR3 controller CPU port: one command in flight, tagged
// in-order responses. Define DDR_CMDQ_TIMEOUT_EN to add the wait-state watchdog.
module ddr_cmd_queue
  import DDR3mempkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = CMDQ_ADDR_W,
  parameter int unsigned DATA_W     = CMDQ_DATA_W,
  parameter int unsigned TAG_W      = CMDQ_TAG_W,
  parameter int unsigned RD_TIMEOUT = 64
) (
  input  logic                     i_cpu_ck,
  input  logic                     i_cpu_reset_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_cmd,
  input  logic [ADDR_W-1:0]        i_req_addr,
  input  logic [DATA_W-1:0]        i_req_wdata,
  input  logic [TAG_W-1:0]         i_req_tag,
  output logic                     o_cpu_valid,
  output logic                     o_cpu_cmd,
  output logic [ADDR_W-1:0]        o_cpu_addr,
  output logic [DATA_W-1:0]        o_cpu_wr_data,
  input  logic                     i_cpu_data_rdy,
  input  logic [DATA_W-1:0]        i_cpu_rd_data,
  input  logic                     i_cpu_rd_data_valid,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic                     o_rsp_cmd,
  output logic [TAG_W-1:0]         o_rsp_tag,
  output logic [DATA_W-1:0]        o_rsp_rdata,
  output logic                     o_rsp_err,
  output logic [$clog2(DEPTH):0]   o_level
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RD_TIMEOUT == 0) begin : g_bad_param
    $error("ddr_cmd_queue: DEPTH must be a power of two >= 2 and RD_TIMEOUT nonzero");
  end

  typedef struct packed {
    logic              cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t      push_entry, head;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic        timeout_hit;

  cmdq_state_t       state_q, state_d;
  logic              cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              got_data_q, got_data_d;

  assign push_entry = {i_req_cmd, i_req_addr, i_req_wdata, i_req_tag};

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (i_cpu_ck),
    .rst_ni  (i_cpu_reset_n),
    .push_i  (i_req_valid),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (o_level)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tag_d      = tag_q;
    rdata_d    = rdata_q;
    got_data_d = got_data_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      Q_IDLE: begin
        // Q_RSP only returns here once the response is taken, so none is pending.
        if (!fifo_empty && i_cpu_data_rdy) begin
          fifo_pop   = 1'b1;
          cmd_d      = head.cmd;
          addr_d     = head.addr;
          wdata_d    = head.wdata;
          tag_d      = head.tag;
          rdata_d    = '0;
          got_data_d = 1'b0;
          state_d    = Q_ISSUE;
        end
      end
      Q_ISSUE: state_d = Q_WAIT_BUSY;
      Q_WAIT_BUSY: begin
        if (timeout_hit)         state_d = Q_RSP;
        else if (!i_cpu_data_rdy) state_d = Q_WAIT_DONE;
      end
      Q_WAIT_DONE: begin
        if (timeout_hit) begin
          rdata_d = '0;
          state_d = Q_RSP;
        end else begin
          if (cmd_q == CMD_READ && i_cpu_rd_data_valid && !got_data_q) begin
            rdata_d    = i_cpu_rd_data;
            got_data_d = 1'b1;
          end
          if (i_cpu_data_rdy && (cmd_q == CMD_WRITE || got_data_d)) state_d = Q_RSP;
        end
      end
      Q_RSP: begin
        if (i_rsp_ready) state_d = Q_IDLE;
      end
      default: state_d = Q_IDLE;
    endcase
  end

  always_ff @(posedge i_cpu_ck or negedge i_cpu_reset_n) begin
    if (!i_cpu_reset_n) begin
      state_q    <= Q_IDLE;
      cmd_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tag_q      <= '0;
      rdata_q    <= '0;
      got_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tag_q      <= tag_d;
      rdata_q    <= rdata_d;
      got_data_q <= got_data_d;
    end
  end

`ifdef DDR_CMDQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);

  logic [TW-1:0] wd_cnt_q;
  logic          err_q;
  logic          in_wait;

  assign in_wait     = (state_q == Q_WAIT_BUSY) || (state_q == Q_WAIT_DONE);
  assign timeout_hit = in_wait && (wd_cnt_q == TW'(RD_TIMEOUT - 1));
  assign o_rsp_err   = err_q;

  always_ff @(posedge i_cpu_ck or negedge i_cpu_reset_n) begin
    if (!i_cpu_reset_n) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (!in_wait || timeout_hit) wd_cnt_q <= '0;
      else                         wd_cnt_q <= wd_cnt_q + 1'b1;
      if (fifo_pop)         err_q <= 1'b0;
      else if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign o_rsp_err   = 1'b0;
`endif

  assign o_req_ready   = !fifo_full;
  assign o_cpu_valid   = (state_q == Q_ISSUE);
  assign o_cpu_cmd     = cmd_q;
  assign o_cpu_addr    = addr_q;
  assign o_cpu_wr_data = wdata_q;
  assign o_rsp_valid   = (state_q == Q_RSP);
  assign o_rsp_cmd     = cmd_q;
  assign o_rsp_tag     = tag_q;
  assign o_rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_ddr_cmd_queue.sv
// Scoreboard bench for ddr_cmd_queue: host driver, controller model and response monitor.
module tb_ddr_cmd_queue;
  import DDR3mempkg::*;

  localparam int unsigned DEPTH = 4, ADDR_W = 27, DATA_W = 64, TAG_W = 4, RD_TIMEOUT = 64;
  localparam int unsigned LW = 3;

  logic              clk = 1'b0, rst_n = 1'b1;
  logic              req_valid = 1'b0, req_ready, req_cmd = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              cpu_valid, cpu_cmd;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              cpu_rdy = 1'b1, rd_valid = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              rsp_valid, rsp_ready = 1'b0, rsp_cmd, rsp_err;
  logic [TAG_W-1:0]  rsp_tag;
  logic [DATA_W-1:0] rsp_rdata;
  logic [LW-1:0]     level;

  always #5 clk = ~clk;

  ddr_cmd_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .i_cpu_ck            (clk),
    .i_cpu_reset_n       (rst_n),
    .i_req_valid         (req_valid),
    .o_req_ready         (req_ready),
    .i_req_cmd           (req_cmd),
    .i_req_addr          (req_addr),
    .i_req_wdata         (req_wdata),
    .i_req_tag           (req_tag),
    .o_cpu_valid         (cpu_valid),
    .o_cpu_cmd           (cpu_cmd),
    .o_cpu_addr          (cpu_addr),
    .o_cpu_wr_data       (cpu_wr_data),
    .i_cpu_data_rdy      (cpu_rdy),
    .i_cpu_rd_data       (rd_data),
    .i_cpu_rd_data_valid (rd_valid),
    .o_rsp_valid         (rsp_valid),
    .i_rsp_ready         (rsp_ready),
    .o_rsp_cmd           (rsp_cmd),
    .o_rsp_tag           (rsp_tag),
    .o_rsp_rdata         (rsp_rdata),
    .o_rsp_err           (rsp_err),
    .o_level             (level)
  );

  typedef struct packed {
    logic              cmd;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  req_entry_t req_q[$];
  rsp_t       rsp_q[$];
  int         tag_log[$];
  int         n_tests = 0, n_fail = 0;
  int         n_push = 0, n_issue = 0, n_rsp = 0;

  // Controller-model and host-side behaviour knobs.
  bit          ctl_hold = 0, ctl_stall = 0, ctl_silent = 0, ctl_dup = 0, ctl_fixed = 0;
  bit          ctl_busy = 0, rsp_stall = 0;
  logic [63:0] ctl_data = '0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Called at a negedge; returns at the negedge after the request is accepted.
  task automatic send(input logic cmd, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wdata, input logic [TAG_W-1:0] tag);
    int waited = 0;
    req_valid = 1'b1; req_cmd = cmd; req_addr = addr; req_wdata = wdata; req_tag = tag;
    while (!req_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("send_accept", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    req_q.push_back('{cmd: cmd, addr: addr, wdata: wdata, tag: tag});
    n_push++;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int i = 0;
    while ((req_q.size() != 0 || rsp_q.size() != 0 || ctl_busy) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    if (i >= 3000) check("drain_pending", req_q.size() + rsp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Controller model: checks each issued command against the host request order.
  initial begin
    req_entry_t  e;
    logic [63:0] rdata;
    int          cyc;
    forever begin
      @(negedge clk);
      cpu_rdy = !ctl_hold;
      if (cpu_valid) begin
        ctl_busy = 1;
        n_issue++;
        rdata = ctl_fixed ? ctl_data : {$urandom, $urandom};
        if (req_q.size() == 0) begin
          check("unexpected_issue", cpu_valid, 0);
          e = '0;
        end else begin
          e = req_q.pop_front();
          check("cpu_cmd", cpu_cmd, e.cmd);
          check("cpu_addr", cpu_addr, e.addr);
          if (e.cmd == CMD_WRITE) check("cpu_wr_data", cpu_wr_data, e.wdata);
          if (ctl_silent)
            rsp_q.push_back('{cmd: e.cmd, tag: e.tag, rdata: '0, err: 1'b1});
          else
            rsp_q.push_back('{cmd: e.cmd, tag: e.tag,
                              rdata: (e.cmd == CMD_WRITE) ? '0 : rdata, err: 1'b0});
        end
        @(negedge clk);
        check("cpu_valid_pulse", cpu_valid, 0);
        if (ctl_silent) begin
          cyc = 1;
          cpu_rdy = 1'b0;
          while (!rsp_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
          end
          check("timeout_latency", (cyc >= RD_TIMEOUT && cyc <= RD_TIMEOUT + 2), 1);
          cpu_rdy = 1'b1;
          @(negedge clk);
          rd_valid = 1'b1; rd_data = {$urandom, $urandom};
          @(negedge clk);
          rd_valid = 1'b0;
        end else begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          cpu_rdy = 1'b0;
          @(negedge clk);
          cyc = 0;
          while (ctl_stall && cyc < 2000) begin
            @(negedge clk);
            cyc++;
          end
          repeat ($urandom_range(0, 3)) @(negedge clk);
          if (e.cmd == CMD_READ) begin
            rd_valid = 1'b1; rd_data = rdata;
            @(negedge clk);
            if (ctl_dup || $urandom_range(0, 1) == 1) begin
              rd_data = ~rdata;
              @(negedge clk);
            end
            rd_valid = 1'b0;
          end
          repeat ($urandom_range(0, 3)) @(negedge clk);
          cpu_rdy = 1'b1;
        end
        ctl_busy = 0;
      end
    end
  end

  // Response monitor: compares every presented response against the scoreboard head.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      rsp_ready = rsp_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 0);
        end else begin
          r = rsp_q[0];
          check("rsp_cmd", rsp_cmd, r.cmd);
          check("rsp_tag", rsp_tag, r.tag);
          check("rsp_rdata", rsp_rdata, r.rdata);
          check("rsp_err", rsp_err, r.err);
          if (rsp_ready) begin
            void'(rsp_q.pop_front());
            tag_log.push_back(int'(r.tag));
            n_rsp++;
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cpu_valid"}, cpu_valid, 0);
    check({pfx, "_cpu_cmd"}, cpu_cmd, 0);
    check({pfx, "_cpu_addr"}, cpu_addr, 0);
    check({pfx, "_cpu_wr_data"}, cpu_wr_data, 0);
    check({pfx, "_rsp_valid"}, rsp_valid, 0);
    check({pfx, "_rsp_cmd"}, rsp_cmd, 0);
    check({pfx, "_rsp_tag"}, rsp_tag, 0);
    check({pfx, "_rsp_rdata"}, rsp_rdata, 0);
    check({pfx, "_rsp_err"}, rsp_err, 0);
    check({pfx, "_level"}, level, 0);
    check({pfx, "_req_ready"}, req_ready, 1);
  endtask

  initial begin
    int base, k, rsp_before;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write, with the one-cycle no-bypass latency.
    send(CMD_WRITE, 27'h0001C08, 64'hDEADBEEF_01234567, 4'd3);
    check("nobypass_valid", cpu_valid, 0);
    check("nobypass_level", level, 1);
    @(negedge clk);
    check("issue_valid", cpu_valid, 1);
    check("issue_level", level, 0);
    wait_drain();

    // Single read with a duplicate data strobe.
    ctl_fixed = 1; ctl_dup = 1; ctl_data = 64'hA5A5_5A5A_0F0F_F0F0;
    send(CMD_READ, 27'h2345678, 64'h0, 4'd5);
    wait_drain();
    ctl_fixed = 0; ctl_dup = 0;

    // Fill with the controller busy; the fifth request waits for the first pop.
    ctl_hold = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++)
      send(1'(i & 1), ADDR_W'($urandom), {$urandom, $urandom}, TAG_W'(8 + i));
    check("full_level", level, 4);
    check("full_ready", req_ready, 0);
    k = n_issue;
    fork
      send(CMD_WRITE, 27'h0000100, 64'h5555, 4'd12);
      begin
        repeat (3) @(negedge clk);
        check("held_level", level, 4);
        check("held_ready", req_ready, 0);
        check("held_no_issue", n_issue, k);
        ctl_hold = 0;
      end
    join
    wait_drain();

    // Ordering and response back-pressure.
    base = tag_log.size();
    rsp_stall = 1;
    send(CMD_WRITE, 27'h0000010, 64'h1111, 4'd1);
    send(CMD_READ, 27'h0000020, 64'h0, 4'd2);
    send(CMD_WRITE, 27'h0000030, 64'h3333, 4'd3);
    for (int i = 0; i < 200 && !rsp_valid; i++) @(negedge clk);
    check("stall_rsp_seen", rsp_valid, 1);
    k = n_issue;
    repeat (10) begin
      @(negedge clk);
      check("stall_rsp_hold", rsp_valid, 1);
    end
    check("stall_no_issue", n_issue, k);
    check("stall_level", level, 2);
    rsp_stall = 0;
    wait_drain();
    check("order_count", tag_log.size() - base, 3);
    if (tag_log.size() - base == 3) begin
      check("order_0", tag_log[base], 1);
      check("order_1", tag_log[base + 1], 2);
      check("order_2", tag_log[base + 2], 3);
    end

    // Asynchronous reset while a read waits for data with two more queued.
    ctl_stall = 1;
    send(CMD_READ, 27'h0000F01, 64'h0, 4'd7);
    send(CMD_READ, 27'h0000F02, 64'h0, 4'd8);
    send(CMD_READ, 27'h0000F03, 64'h0, 4'd9);
    for (int i = 0; i < 100 && cpu_rdy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("pre_reset_level", level, 2);
    rsp_before = n_rsp;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    ctl_stall = 0;
    for (int i = 0; i < 100 && ctl_busy; i++) @(negedge clk);
    req_q.delete();
    rsp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_no_rsp", n_rsp, rsp_before);
    check("post_reset_level", level, 0);

`ifdef DDR_CMDQ_TIMEOUT_EN
    // Read that never gets data: watchdog error response.
    ctl_silent = 1;
    send(CMD_READ, 27'h0000ABC, 64'h0, 4'hA);
    wait_drain();
    ctl_silent = 0;
`endif

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      send(1'($urandom), ADDR_W'($urandom), {$urandom, $urandom}, TAG_W'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    wait_drain();
    check("all_responses", n_rsp, n_push - 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete (t=%0t)", $time);
    $fatal(1, "global timeout");
  end

endmodule
